ad9280_scop_acq_sequencer: RTL and testbench

Acquisition sequencer in the adc_clk domain that drives the AD9280 scope capture core's `sampling_enable` and `software_trigger` inputs. It arms the core, waits for a trigger with an optional auto-trigger timeout, detects frame completion, inserts a holdoff, and re-arms. It runs single-shot or for N frames, so software issues one run command instead of toggling core controls per frame. The capture core operates with `trigger_enable=1` under this block.

---
 rtl/ad9280_scop_acq_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ad9280_scop_acq_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9280_scop_acq_sequencer.sv
// Acquisition sequencer for the AD9280 scope capture core: arm, wait for trigger, capture, holdoff, re-arm.
// Optional auto-trigger timeout logic is built only when ACQ_SEQ_AUTO_TIMEOUT_EN is defined.
module ad9280_scop_acq_sequencer #(
  parameter int unsigned TIMEOUT_WIDTH   = 24,
  parameter int unsigned HOLDOFF_WIDTH   = 16,
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst_n,
  input  logic                       cfg_run,
  input  logic                       cfg_single,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_frames,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg_auto_timeout,
  input  logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff,
  input  logic                       core_trigger_detected,
  input  logic                       core_acq_complete,
  output logic                       core_sampling_enable,
  output logic                       core_software_trigger,
  output logic                       seq_busy,
  output logic                       seq_done,
  output logic                       timeout_fired,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [2:0]                 seq_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    HOLDOFF   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [HOLDOFF_WIDTH-1:0]   r_hold;
  logic [HOLDOFF_WIDTH-1:0]   w_hold_nxt;
  logic [HOLDOFF_WIDTH-1:0]   w_hold_max;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic [FRAME_CNT_WIDTH-1:0] w_fc_nxt;
  logic [FRAME_CNT_WIDTH-1:0] w_fc_inc;
  logic                       w_fire;
  logic                       r_en;
  logic                       r_busy;
  logic                       r_done;

`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0]   r_tmo;
  logic [TIMEOUT_WIDTH-1:0]   w_tmo_nxt;
  logic                       r_sw_trig;
  logic                       r_tmo_fired;
`else
  logic                       w_unused_tmo;
  assign w_unused_tmo = ^cfg_auto_timeout;
`endif

  // Holdoff is never shorter than 2 cycles so the core can drop back to its own idle
  assign w_hold_max = (cfg_holdoff < HOLDOFF_WIDTH'(2)) ? HOLDOFF_WIDTH'(2) : cfg_holdoff;
  assign w_fc_inc   = r_frame_count + FRAME_CNT_WIDTH'(1);

  // Next-state and counter updates; deassertion of cfg_run overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_fc_nxt    = r_frame_count;
    w_fire      = 1'b0;
`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
    w_tmo_nxt   = r_tmo;
`endif
    if (!cfg_run) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_fc_nxt    = '0;
        end
        ARM: begin
          w_state_nxt = WAIT_TRIG;
`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
          w_tmo_nxt   = '0;
`endif
        end
        WAIT_TRIG: begin
`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
          w_tmo_nxt = r_tmo + TIMEOUT_WIDTH'(1);
          if (core_trigger_detected) begin
            w_state_nxt = CAPTURE;
          end else if ((cfg_auto_timeout != '0) &&
                       (r_tmo == cfg_auto_timeout - TIMEOUT_WIDTH'(1))) begin
            w_state_nxt = CAPTURE;
            w_fire      = 1'b1;
          end
`else
          if (core_trigger_detected) begin
            w_state_nxt = CAPTURE;
          end
`endif
        end
        CAPTURE: begin
          w_hold_nxt = '0;
          if (core_acq_complete) begin
            w_fc_nxt = w_fc_inc;
            if (cfg_single || ((cfg_frames != '0) && (w_fc_inc == cfg_frames))) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (r_hold >= w_hold_max - HOLDOFF_WIDTH'(1)) begin
            w_state_nxt = ARM;
          end else begin
            w_hold_nxt = r_hold + HOLDOFF_WIDTH'(1);
          end
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counters and status flags; flags are decoded from the next state so they track r_state
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_state       <= IDLE;
      r_hold        <= '0;
      r_frame_count <= '0;
      r_en          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_frame_count <= w_fc_nxt;
      r_en          <= (w_state_nxt == ARM) || (w_state_nxt == WAIT_TRIG) ||
                       (w_state_nxt == CAPTURE);
      r_busy        <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done        <= (w_state_nxt == DONE);
    end
  end

`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
  // Forced-trigger pulse is visible in the first CAPTURE cycle after the timeout
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_tmo       <= '0;
      r_sw_trig   <= 1'b0;
      r_tmo_fired <= 1'b0;
    end else begin
      r_tmo       <= w_tmo_nxt;
      r_sw_trig   <= w_fire;
      r_tmo_fired <= w_fire;
    end
  end

  assign core_software_trigger = r_sw_trig;
  assign timeout_fired         = r_tmo_fired;
`else
  logic w_unused_fire;
  assign w_unused_fire         = w_fire;
  assign core_software_trigger = 1'b0;
  assign timeout_fired         = 1'b0;
`endif

  assign core_sampling_enable = r_en;
  assign seq_busy             = r_busy;
  assign seq_done             = r_done;
  assign frame_count          = r_frame_count;
  assign seq_state            = r_state;

endmodule

// File: tb/tb_ad9280_scop_acq_sequencer.sv
// Directed self-checking bench for ad9280_scop_acq_sequencer; expectations follow ACQ_SEQ_AUTO_TIMEOUT_EN.
module tb_ad9280_scop_acq_sequencer;

  localparam int unsigned TW = 24;
  localparam int unsigned HW = 16;
  localparam int unsigned FW = 8;

  localparam int S_IDLE = 0, S_ARM = 1, S_WAIT = 2, S_CAP = 3, S_HOLD = 4, S_DONE = 5;

  logic          adc_clk = 1'b0;
  logic          adc_rst_n;
  logic          cfg_run;
  logic          cfg_single;
  logic [FW-1:0] cfg_frames;
  logic [TW-1:0] cfg_auto_timeout;
  logic [HW-1:0] cfg_holdoff;
  logic          core_trigger_detected;
  logic          core_acq_complete;
  logic          core_sampling_enable;
  logic          core_software_trigger;
  logic          seq_busy;
  logic          seq_done;
  logic          timeout_fired;
  logic [FW-1:0] frame_count;
  logic [2:0]    seq_state;

  int n_checks = 0;
  int n_fail   = 0;
  int sw_cnt   = 0;

  ad9280_scop_acq_sequencer #(
    .TIMEOUT_WIDTH(TW), .HOLDOFF_WIDTH(HW), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n),
    .cfg_run(cfg_run), .cfg_single(cfg_single), .cfg_frames(cfg_frames),
    .cfg_auto_timeout(cfg_auto_timeout), .cfg_holdoff(cfg_holdoff),
    .core_trigger_detected(core_trigger_detected), .core_acq_complete(core_acq_complete),
    .core_sampling_enable(core_sampling_enable), .core_software_trigger(core_software_trigger),
    .seq_busy(seq_busy), .seq_done(seq_done), .timeout_fired(timeout_fired),
    .frame_count(frame_count), .seq_state(seq_state)
  );

  always #5 adc_clk = ~adc_clk;

  always @(posedge adc_clk) if (core_software_trigger === 1'b1) sw_cnt <= sw_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge adc_clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int st, input int en, input int busy,
                          input int done, input int fc);
    chk({tag, ".state"}, int'(seq_state), st);
    chk({tag, ".en"},    int'(core_sampling_enable), en);
    chk({tag, ".busy"},  int'(seq_busy), busy);
    chk({tag, ".done"},  int'(seq_done), done);
    chk({tag, ".fc"},    int'(frame_count), fc);
  endtask

  initial begin
    int n;
    int bad;
    int sw0;
    int comps;
    int wrapped;
    int done_seen;
    int prev;
    int cyc;

    adc_rst_n = 1'b0; cfg_run = 1'b0; cfg_single = 1'b0; cfg_frames = '0;
    cfg_auto_timeout = '0; cfg_holdoff = '0;
    core_trigger_detected = 1'b0; core_acq_complete = 1'b0;
    #1;
    chk_outs("reset", S_IDLE, 0, 0, 0, 0);
    chk("reset.swtrig", int'(core_software_trigger), 0);
    chk("reset.tmo", int'(timeout_fired), 0);
    tick(2);
    adc_rst_n = 1'b1;
    tick(1);
    chk("idle_hold.state", int'(seq_state), S_IDLE);

    // single shot
    cfg_single = 1'b1; cfg_holdoff = HW'(5); cfg_run = 1'b1;
    tick(1);
    chk_outs("ss_arm", S_ARM, 1, 1, 0, 0);
    tick(1);
    chk_outs("ss_wait", S_WAIT, 1, 1, 0, 0);
    tick(19);
    chk("ss_wait20.state", int'(seq_state), S_WAIT);
    core_trigger_detected = 1'b1;
    tick(1);
    core_trigger_detected = 1'b0;
    chk_outs("ss_cap", S_CAP, 1, 1, 0, 0);
    tick(299);
    chk("ss_cap300.state", int'(seq_state), S_CAP);
    core_acq_complete = 1'b1;
    tick(1);
    core_acq_complete = 1'b0;
    chk_outs("ss_done", S_DONE, 0, 0, 1, 1);
    chk("ss_nopulse", sw_cnt, 0);
    tick(3);
    chk_outs("ss_done_hold", S_DONE, 0, 0, 1, 1);
    cfg_run = 1'b0;
    tick(1);
    chk_outs("ss_abort", S_IDLE, 0, 0, 0, 1);

    // multi-frame with holdoff 5
    cfg_single = 1'b0; cfg_frames = FW'(3); cfg_holdoff = HW'(5); cfg_run = 1'b1;
    tick(1);
    for (int f = 0; f < 3; f++) begin
      chk("mf_arm.state", int'(seq_state), S_ARM);
      tick(1);
      chk("mf_wait.state", int'(seq_state), S_WAIT);
      core_trigger_detected = 1'b1;
      tick(1);
      core_trigger_detected = 1'b0;
      chk("mf_cap.state", int'(seq_state), S_CAP);
      tick(3);
      core_acq_complete = 1'b1;
      tick(1);
      core_acq_complete = 1'b0;
      chk("mf_fc", int'(frame_count), f + 1);
      chk("mf_en_off", int'(core_sampling_enable), 0);
      if (f < 2) begin
        chk("mf_hold.state", int'(seq_state), S_HOLD);
        n = 1; bad = 0;
        for (int i = 0; i < 50; i++) begin
          if (core_sampling_enable !== 1'b0) bad = 1;
          tick(1);
          if (seq_state == 3'(S_HOLD)) n++;
          else break;
        end
        chk("mf_hold_len", n, 5);
        chk("mf_hold_en", bad, 0);
      end else begin
        chk_outs("mf_done", S_DONE, 0, 0, 1, 3);
      end
    end
    cfg_run = 1'b0;
    tick(1);

    // holdoff minimum of 2 cycles
    cfg_frames = FW'(2); cfg_holdoff = HW'(0); cfg_run = 1'b1;
    tick(2);
    core_trigger_detected = 1'b1;
    tick(1);
    core_trigger_detected = 1'b0;
    core_acq_complete = 1'b1;
    tick(1);
    core_acq_complete = 1'b0;
    chk("hmin_hold.state", int'(seq_state), S_HOLD);
    tick(1);
    chk("hmin_hold2.state", int'(seq_state), S_HOLD);
    tick(1);
    chk("hmin_arm.state", int'(seq_state), S_ARM);
    cfg_run = 1'b0;
    tick(1);

    // auto-timeout with no hardware trigger
    cfg_single = 1'b1; cfg_frames = '0; cfg_auto_timeout = TW'(100); cfg_run = 1'b1;
    sw0 = sw_cnt;
    tick(2);
    chk("to_wait1.state", int'(seq_state), S_WAIT);
    tick(99);
    chk("to_wait100.state", int'(seq_state), S_WAIT);
    chk("to_wait100.sw", int'(core_software_trigger), 0);
    tick(1);
`ifdef ACQ_SEQ_AUTO_TIMEOUT_EN
    chk("to_fire.state", int'(seq_state), S_CAP);
    chk("to_fire.sw", int'(core_software_trigger), 1);
    chk("to_fire.tmo", int'(timeout_fired), 1);
    tick(1);
    chk("to_after.sw", int'(core_software_trigger), 0);
    chk("to_after.tmo", int'(timeout_fired), 0);
    chk("to_after.state", int'(seq_state), S_CAP);
    chk("to_pulses", sw_cnt - sw0, 1);
`else
    tick(1000);
    chk("to_off.state", int'(seq_state), S_WAIT);
    chk("to_off.pulses", sw_cnt - sw0, 0);
    chk("to_off.tmo", int'(timeout_fired), 0);
`endif
    cfg_run = 1'b0;
    tick(1);
    chk("to_abort.state", int'(seq_state), S_IDLE);

    // trigger on the timeout cycle wins, no pulse
    cfg_run = 1'b1;
    sw0 = sw_cnt;
    tick(2);
    tick(99);
    core_trigger_detected = 1'b1;
    tick(1);
    core_trigger_detected = 1'b0;
    chk("tw_cap.state", int'(seq_state), S_CAP);
    chk("tw_cap.sw", int'(core_software_trigger), 0);
    chk("tw_cap.tmo", int'(timeout_fired), 0);
    tick(1);
    chk("tw_pulses", sw_cnt - sw0, 0);

    // abort during capture, restart clears frame_count
    cfg_single = 1'b0; cfg_frames = '0; cfg_holdoff = '0; cfg_auto_timeout = '0;
    core_acq_complete = 1'b1;
    tick(1);
    core_acq_complete = 1'b0;
    chk("ab_hold.fc", int'(frame_count), 1);
    tick(3);
    core_trigger_detected = 1'b1;
    tick(1);
    core_trigger_detected = 1'b0;
    chk("ab_cap.state", int'(seq_state), S_CAP);
    cfg_run = 1'b0;
    tick(1);
    chk_outs("ab_idle", S_IDLE, 0, 0, 0, 1);
    cfg_run = 1'b1;
    tick(1);
    chk_outs("ab_rearm", S_ARM, 1, 1, 0, 0);

    // unlimited run: 260 frames, frame_count wraps, no DONE
    core_trigger_detected = 1'b1; core_acq_complete = 1'b1;
    comps = 0; wrapped = 0; done_seen = 0; prev = int'(frame_count); cyc = 0;
    while (comps < 260 && cyc < 260 * 5 + 50) begin
      tick(1);
      cyc++;
      if (seq_state == 3'(S_DONE) || seq_done) done_seen = 1;
      if (int'(frame_count) != prev) begin
        comps++;
        if (prev == 255 && frame_count == 8'd0) wrapped = 1;
        prev = int'(frame_count);
      end
    end
    core_trigger_detected = 1'b0; core_acq_complete = 1'b0;
    chk("ul_frames", comps, 260);
    chk("ul_fc", int'(frame_count), 4);
    chk("ul_wrap", wrapped, 1);
    chk("ul_nodone", done_seen, 0);
    chk("ul_busy", int'(seq_busy), 1);

    // asynchronous reset mid-run
    adc_rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", S_IDLE, 0, 0, 0, 0);
    chk("rst_mid.sw", int'(core_software_trigger), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
